sipo_deserializer: RTL and testbench

//  Serial-in/parallel-out receiver; the receive end of a serial link driven by a shift-register transmitter.

---
 rtl/sipo_pkg.sv | 23 ++
 rtl/sipo_deserializer_if.sv | 35 +++
 rtl/sipo_shift_core.sv | 44 ++++
 rtl/sipo_deserializer.sv | 206 ++++++++++++++++++++
 tb/tb_sipo_deserializer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO deserializer.
//   sipo_state_t   : receiver FSM state encoding
//   DIR_*          : bit-order codes latched at the start of each frame
//   even_parity    : reduction-XOR helper used for the optional parity check
// Optional feature macro: PARITY_EN. When it is defined, the receiver expects a
// parity bit after each data word.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    // Callers zero-extend narrower vectors; zero bits do not change the XOR.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Bus bundle for the SIPO deserializer.
//   s_in, s_valid, lsb_first : strobed serial input and its bit-order select
//   m_data, m_valid, m_ready : valid/ready parallel output
//   m_perr                   : parity error flag (only when PARITY_EN is defined)
// slave modport  = the deserializer side
// master modport = the serial source / word consumer side
interface sipo_deserializer_if #(
    parameter int N = 8
);
    logic         s_in;
    logic         s_valid;
    logic         lsb_first;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
`ifdef PARITY_EN
    logic         m_perr;
`endif

    modport slave (
        input  s_in, s_valid, lsb_first, m_ready,
`ifdef PARITY_EN
        output m_perr,
`endif
        output m_data, m_valid
    );

    modport master (
        output s_in, s_valid, lsb_first, m_ready,
`ifdef PARITY_EN
        input  m_perr,
`endif
        input  m_data, m_valid
    );
endinterface

// File: rtl/sipo_shift_core.sv
// N-bit bidirectional shift register.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : shift one bit in this cycle
//   dir          : 0 = MSB first (shift left), 1 = LSB first (shift right)
//   clr          : synchronous clear, wins over en
//   din          : serial data bit
//   q            : register contents
// After N shifts in either direction, q holds the word in its natural bit order.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         dir,
    input  logic         clr,
    input  logic         din,
    output logic [N-1:0] q
);

    logic [N-1:0] sr_r;

    // Shift register: clear first, otherwise shift toward the LSB or the MSB end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_r <= {N{1'b0}};
        end else if (clr) begin
            sr_r <= {N{1'b0}};
        end else if (en) begin
            if (dir == DIR_LSB_FIRST) begin
                sr_r <= {din, sr_r[N-1:1]};
            end else begin
                sr_r <= {sr_r[N-2:0], din};
            end
        end else begin
            sr_r <= sr_r;
        end
    end

    assign q = sr_r;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out receiver with a one-word output buffer.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous abort of the partial frame; also clears overrun
//   bus          : sipo_deserializer_if.slave (serial in, valid/ready word out)
//   busy         : a frame is partially received
//   overrun      : sticky; a completed word was dropped because the buffer was full
// Optional feature macro: PARITY_EN (adds a parity bit per frame and bus.m_perr).
// A new frame can be assembled while the previous word waits in the buffer.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    sipo_deserializer_if.slave  bus,
    output logic                busy,
    output logic                overrun
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    sipo_state_t      state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic             dir_r, dir_s;
    logic             busy_r;
    logic             start_s, shift_en_s, complete_s, load_s;
    logic [N-1:0]     q_s, word_s;
    logic [N-1:0]     m_data_r;
    logic             m_valid_r, overrun_r;
`ifdef PARITY_EN
    logic             perr_s, m_perr_r;
`endif

    // The first bit of a frame uses the live bit-order input; later bits use the latched one
    assign dir_s = (state_r == IDLE) ? bus.lsb_first : dir_r;

    sipo_shift_core #(.N(N)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (shift_en_s),
        .dir     (dir_s),
        .clr     (clear),
        .din     (bus.s_in),
        .q       (q_s)
    );

    // State register, bit counter, latched bit order and busy flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            dir_r   <= DIR_MSB_FIRST;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            if (start_s) begin
                dir_r <= bus.lsb_first;
            end else begin
                dir_r <= dir_r;
            end
        end
    end

    // Next-state and counter logic; clear overrides any strobe
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        if (clear) begin
            state_nx_s = IDLE;
            cnt_nx_s   = CNT_ZERO;
        end else if (bus.s_valid) begin
            case (state_r)
                IDLE: begin
                    state_nx_s = SHIFT;
                    cnt_nx_s   = CNT_ONE;
                end
                SHIFT: begin
                    if (cnt_r == LAST_IDX) begin
`ifdef PARITY_EN
                        state_nx_s = PARITY;
                        cnt_nx_s   = cnt_r + CNT_ONE;
`else
                        state_nx_s = IDLE;
                        cnt_nx_s   = CNT_ZERO;
`endif
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end
                PARITY: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = CNT_ZERO;
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_nx_s = state_r;
            cnt_nx_s   = cnt_r;
        end
    end

    // Per-cycle controls: frame start, shift enable, frame completion, buffer load
    always_comb begin
        start_s    = 1'b0;
        shift_en_s = 1'b0;
        complete_s = 1'b0;
        if (!clear && bus.s_valid) begin
            case (state_r)
                IDLE: begin
                    start_s    = 1'b1;
                    shift_en_s = 1'b1;
                end
                SHIFT: begin
                    shift_en_s = 1'b1;
`ifdef PARITY_EN
                    complete_s = 1'b0;
`else
                    complete_s = (cnt_r == LAST_IDX);
`endif
                end
                PARITY: begin
`ifdef PARITY_EN
                    complete_s = 1'b1;
`else
                    complete_s = 1'b0;
`endif
                end
                default: begin
                    complete_s = 1'b0;
                end
            endcase
        end else begin
            shift_en_s = 1'b0;
        end
        // Buffer accepts the new word if it is empty or is being drained this cycle
        load_s = complete_s && (!m_valid_r || bus.m_ready);
    end

    // Completed word: with parity the data is already in the register, otherwise
    // the last data bit is merged here so the word is ready on the strobe edge
    always_comb begin
`ifdef PARITY_EN
        word_s = q_s;
        perr_s = even_parity(64'(q_s)) ^ bus.s_in;
`else
        if (dir_r == DIR_LSB_FIRST) begin
            word_s = {bus.s_in, q_s[N-1:1]};
        end else begin
            word_s = {q_s[N-2:0], bus.s_in};
        end
`endif
    end

    // Output buffer: load on completion, drop valid on handshake; data stays put otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data_r  <= {N{1'b0}};
            m_valid_r <= 1'b0;
`ifdef PARITY_EN
            m_perr_r  <= 1'b0;
`endif
        end else if (load_s) begin
            m_data_r  <= word_s;
            m_valid_r <= 1'b1;
`ifdef PARITY_EN
            m_perr_r  <= perr_s;
`endif
        end else if (m_valid_r && bus.m_ready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    // Sticky overrun: set when a finished word finds the buffer full and not draining
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
        end else if (clear) begin
            overrun_r <= 1'b0;
        end else if (complete_s && m_valid_r && !bus.m_ready) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.m_data  = m_data_r;
    assign bus.m_valid = m_valid_r;
`ifdef PARITY_EN
    assign bus.m_perr  = m_perr_r;
`endif
    assign busy        = busy_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer (N=8): a vector table for the basic
// MSB-first frame, hand sequences for reset/gaps/overrun/clear/parity, then a
// randomized run checked every cycle against a bit-queue reference model.
module tb_sipo_deserializer;

    localparam int N = 8;
`ifdef PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic clear = 1'b0;
    logic busy, overrun;

    sipo_deserializer_if #(.N(N)) bus ();

    sipo_deserializer #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the frame is simply the list of bits received so far
    bit           fq[$];
    bit           fdir;
    logic [N-1:0] md;
    bit           mv, ov, mp;

    typedef struct {
        bit           clr, sv, si, lsb, rdy;
        bit           e_valid;
        logic [N-1:0] e_data;
        bit           e_busy, e_ovr;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        fdir = 1'b0;
        md = '0;
        mv = 1'b0;
        ov = 1'b0;
        mp = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit v, input bit s, input bit l, input bit r);
        bit           done;
        logic [N-1:0] w;
        bit           pe;
        done = 1'b0;
        w = '0;
        pe = 1'b0;
        if (c) begin
            fq.delete();
            ov = 1'b0;
        end else if (v) begin
            if (fq.size() == 0) fdir = l;
            fq.push_back(s);
            if (fq.size() == FL) begin
                done = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (fdir) w[i] = fq[i];
                    else      w[N-1-i] = fq[i];
                end
`ifdef PARITY_EN
                pe = (^w) ^ fq[N];
`endif
                fq.delete();
            end
        end
        if (done && (!mv || r)) begin
            md = w;
            mv = 1'b1;
            mp = pe;
        end else begin
            if (done) ov = 1'b1;
            if (mv && r) mv = 1'b0;
        end
    endtask

    task automatic model_check();
        check("m_valid", bus.m_valid, mv);
        check("m_data", bus.m_data, md);
        check("busy", busy, fq.size() != 0);
        check("overrun", overrun, ov);
`ifdef PARITY_EN
        check("m_perr", bus.m_perr, mp);
`endif
    endtask

    task automatic cycle(input bit c, input bit v, input bit s, input bit l, input bit r);
        clear       = c;
        bus.s_valid = v;
        bus.s_in    = s;
        bus.lsb_first = l;
        bus.m_ready = r;
        @(posedge clk);
        model_step(c, v, s, l, r);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        clear = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_in = 1'b0;
        bus.m_ready = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_data", bus.m_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Sends one frame (plus an even parity bit when parity is enabled) with random gaps
    task automatic send_frame(input logic [N-1:0] w, input bit l, input bit r, input int max_gap);
        bit b;
        for (int k = 0; k < N; k++) begin
            b = l ? w[k] : w[N-1-k];
            for (int g = $urandom_range(0, max_gap); g > 0; g--) cycle(1'b0, 1'b0, 1'b0, l, r);
            cycle(1'b0, 1'b1, b, l, r);
        end
`ifdef PARITY_EN
        cycle(1'b0, 1'b1, ^w, l, r);
`endif
    endtask

    function automatic vec_t mk(input bit c, input bit v, input bit s, input bit l, input bit r,
                                input bit ev, input logic [N-1:0] ed, input bit eb, input bit eo);
        vec_t t;
        t.clr = c; t.sv = v; t.si = s; t.lsb = l; t.rdy = r;
        t.e_valid = ev; t.e_data = ed; t.e_busy = eb; t.e_ovr = eo;
        return t;
    endfunction

    initial begin
        logic [N-1:0] a5;
        bit c, v, s, l, r;
        a5 = 8'hA5;
        bus.s_valid = 1'b0;
        bus.s_in = 1'b0;
        bus.lsb_first = 1'b0;
        bus.m_ready = 1'b0;

        // Vector table: MSB-first 0xA5, output valid for exactly one clk after the last strobe
        for (int k = 0; k < N - 1; k++)
            tbl.push_back(mk(1'b0, 1'b1, a5[N-1-k], 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
`ifdef PARITY_EN
        tbl.push_back(mk(1'b0, 1'b1, a5[0], 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0));
`else
        tbl.push_back(mk(1'b0, 1'b1, a5[0], 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0));
`endif
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0));

        #2;
        do_reset();
        foreach (tbl[i]) begin
            cycle(tbl[i].clr, tbl[i].sv, tbl[i].si, tbl[i].lsb, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), bus.m_valid, tbl[i].e_valid);
            check($sformatf("tbl%0d_data", i), bus.m_data, tbl[i].e_data);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_ovr", i), overrun, tbl[i].e_ovr);
        end

        // Reset in the middle of a frame, then a clean frame
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        check("t1_data", bus.m_data, 8'hA5);
        check("t1_valid", bus.m_valid, 1'b1);

        // LSB-first with idle gaps; busy is checked every cycle by the model
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h12, 1'b1, 1'b1, 3);
        check("t3_data", bus.m_data, 8'h12);
        check("t3_busy", busy, 1'b0);

        // Full buffer: second word dropped, overrun sticky until clear
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h12, 1'b0, 1'b0, 1);
        send_frame(8'h34, 1'b0, 1'b0, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_data", bus.m_data, 8'h12);
        check("t4_ovr", overrun, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_drain", bus.m_valid, 1'b0);
        check("t4_ovr_held", overrun, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_ovr_clr", overrun, 1'b0);

        // Abort after 3 bits; clear wins over a simultaneous strobe
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t5_busy", busy, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t5_abort", busy, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        check("t5_data", bus.m_data, 8'hFF);
        check("t5_valid", bus.m_valid, 1'b1);

`ifdef PARITY_EN
        // Parity bit 0 then 1 after 0xA5 (which has even weight)
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < N; k++) cycle(1'b0, 1'b1, a5[N-1-k], 1'b0, 1'b1);
            cycle(1'b0, 1'b1, p[0], 1'b0, 1'b1);
            check($sformatf("t6_perr%0d", p), bus.m_perr, p[0]);
            check($sformatf("t6_data%0d", p), bus.m_data, 8'hA5);
        end
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                c = ($urandom_range(0, 39) == 0);
                v = ($urandom_range(0, 3) != 0);
                s = $urandom_range(0, 1);
                l = $urandom_range(0, 1);
                r = $urandom_range(0, 1);
                cycle(c, v, s, l, r);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
